// File: rtl/adc_frame_fifo_cdc.sv
// ADC frame capture into an asynchronous Gray-pointer FIFO, delivered to the
// AXI_CLK domain as a show-ahead valid/ready stream with overflow accounting.
module adc_frame_fifo_cdc #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 14,
  parameter int ADDR_W = 4
) (
  input  logic                       RESET_N,
  input  logic                       DATA_CLK,
  input  logic                       FRAME_CLK,
  input  logic [NUM_CH*DATA_W-1:0]   ADC_DATA,
  output logic [15:0]                OVERFLOW_COUNT,
  input  logic                       AXI_CLK,
  input  logic                       AXI_READY,
  output logic                       AXI_DATA_VALID,
  output logic [NUM_CH*DATA_W-1:0]   AXI_DATA,
  output logic [ADDR_W:0]            FIFO_LEVEL
);

  localparam int FRAME_W = NUM_CH * DATA_W;
  localparam int PTR_W   = ADDR_W + 1;
  localparam int DEPTH   = 1 << ADDR_W;

  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [FRAME_W-1:0] mem [DEPTH];

  // ---------------- write domain (DATA_CLK) ----------------
  logic             frame_prev;
  logic             full;
  logic [PTR_W-1:0] wptr_bin, wptr_gray;
  logic [PTR_W-1:0] rptr_gray_q1, rptr_gray_q2;
  logic [PTR_W-1:0] wptr_bin_next, wptr_gray_next;
  logic             capture, do_write;
  logic [PTR_W-1:0] rptr_gray;

  always_comb begin
    capture        = FRAME_CLK & ~frame_prev;
    do_write       = capture & ~full;
    wptr_bin_next  = wptr_bin + {{ADDR_W{1'b0}}, do_write};
    wptr_gray_next = bin2gray(wptr_bin_next);
  end

  // Full once the post-write pointer sits exactly one lap ahead of the read pointer.
  always_ff @(posedge DATA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      frame_prev     <= 1'b1;
      wptr_bin       <= '0;
      wptr_gray      <= '0;
      rptr_gray_q1   <= '0;
      rptr_gray_q2   <= '0;
      full           <= 1'b0;
      OVERFLOW_COUNT <= '0;
    end else begin
      frame_prev   <= FRAME_CLK;
      rptr_gray_q1 <= rptr_gray;
      rptr_gray_q2 <= rptr_gray_q1;
      wptr_bin     <= wptr_bin_next;
      wptr_gray    <= wptr_gray_next;
      full         <= (wptr_gray_next ==
                       {~rptr_gray_q2[PTR_W-1:PTR_W-2], rptr_gray_q2[PTR_W-3:0]});
      if (capture && full && OVERFLOW_COUNT != 16'hFFFF)
        OVERFLOW_COUNT <= OVERFLOW_COUNT + 16'd1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge DATA_CLK) begin
    if (do_write) mem[wptr_bin[ADDR_W-1:0]] <= ADC_DATA;
  end

  // ---------------- read domain (AXI_CLK) ----------------
  // NOTE: reset asserts asynchronously but releases through two AXI_CLK flops.
  logic [1:0] rd_rst_sync;
  logic       rd_rst_n;

  always_ff @(posedge AXI_CLK or negedge RESET_N) begin
    if (!RESET_N) rd_rst_sync <= 2'b00;
    else          rd_rst_sync <= {rd_rst_sync[0], 1'b1};
  end
  assign rd_rst_n = rd_rst_sync[1];

  logic [PTR_W-1:0] wptr_gray_q1, wptr_gray_q2;
  logic [PTR_W-1:0] fetch_bin, rptr_bin, rptr_bin_next;
  logic             fetch_empty, load, pop;

  // fetch_bin runs ahead of rptr_bin by the frame held in the output register,
  // so the write side only sees a slot freed once that frame is transferred.
  always_comb begin
    fetch_empty   = (bin2gray(fetch_bin) == wptr_gray_q2);
    pop           = AXI_DATA_VALID & AXI_READY;
    load          = ~fetch_empty & (~AXI_DATA_VALID | AXI_READY);
    rptr_bin_next = rptr_bin + {{ADDR_W{1'b0}}, pop};
  end

  always_ff @(posedge AXI_CLK or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wptr_gray_q1   <= '0;
      wptr_gray_q2   <= '0;
      fetch_bin      <= '0;
      rptr_bin       <= '0;
      rptr_gray      <= '0;
      AXI_DATA_VALID <= 1'b0;
      AXI_DATA       <= '0;
      FIFO_LEVEL     <= '0;
    end else begin
      wptr_gray_q1 <= wptr_gray;
      wptr_gray_q2 <= wptr_gray_q1;
      fetch_bin    <= fetch_bin + {{ADDR_W{1'b0}}, load};
      rptr_bin     <= rptr_bin_next;
      rptr_gray    <= bin2gray(rptr_bin_next);
      FIFO_LEVEL   <= gray2bin(wptr_gray_q2) - rptr_bin;
      if (load) begin
        AXI_DATA_VALID <= 1'b1;
        AXI_DATA       <= mem[fetch_bin[ADDR_W-1:0]];
      end else if (pop) begin
        AXI_DATA_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_fifo_cdc.sv
// Randomised bench for adc_frame_fifo_cdc: frames are tracked in a scoreboard
// queue that models a DEPTH-frame buffer with saturating drop counting.
`timescale 1ps/1ps
module tb_adc_frame_fifo_cdc;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 14;
  localparam int ADDR_W = 4;
  localparam int FW     = NUM_CH * DATA_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              RESET_N   = 1'b0;
  logic              DATA_CLK  = 1'b0;
  logic              FRAME_CLK = 1'b1;
  logic [FW-1:0]     ADC_DATA  = '0;
  logic              AXI_CLK   = 1'b0;
  logic              AXI_READY = 1'b0;
  logic [15:0]       OVERFLOW_COUNT;
  logic              AXI_DATA_VALID;
  logic [FW-1:0]     AXI_DATA;
  logic [ADDR_W:0]   FIFO_LEVEL;

  adc_frame_fifo_cdc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .RESET_N        (RESET_N),
    .DATA_CLK       (DATA_CLK),
    .FRAME_CLK      (FRAME_CLK),
    .ADC_DATA       (ADC_DATA),
    .OVERFLOW_COUNT (OVERFLOW_COUNT),
    .AXI_CLK        (AXI_CLK),
    .AXI_READY      (AXI_READY),
    .AXI_DATA_VALID (AXI_DATA_VALID),
    .AXI_DATA       (AXI_DATA),
    .FIFO_LEVEL     (FIFO_LEVEL)
  );

  // 37.5 MHz data clock, 100 MHz AXI clock (gateable to shorten the long overflow run)
  logic axi_en = 1'b1;
  always #13333 DATA_CLK = ~DATA_CLK;
  always begin
    #5000;
    if (axi_en) AXI_CLK = ~AXI_CLK;
  end

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [FW-1:0] sb[$];
  int            exp_ovf  = 0;
  int            ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
  int            valid_cycles = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Consumer: drive READY away from the active edge and score every transfer.
  always @(negedge AXI_CLK) begin
    logic [FW-1:0] exp_frame;
    case (ready_mode)
      0:       AXI_READY = 1'b0;
      1:       AXI_READY = 1'b1;
      default: AXI_READY = 1'($urandom_range(0, 1));
    endcase
    if (AXI_DATA_VALID) begin
      valid_cycles++;
      if (AXI_READY) begin
        if (sb.size() == 0) begin
          check("unexpected_frame", 64'(sb.size()), 64'd1);
        end else begin
          exp_frame = sb.pop_front();
          check("frame", 64'(AXI_DATA), 64'(exp_frame));
        end
      end
    end
  end

  function automatic logic [FW-1:0] rand_frame();
    return FW'({$urandom, $urandom});
  endfunction

  // Called at a DATA_CLK negedge; one rising FRAME_CLK edge carrying d.
  task automatic send_frame(input logic [FW-1:0] d, input int hi, input int lo);
    ADC_DATA  = d;
    FRAME_CLK = 1'b1;
    if (sb.size() < DEPTH) sb.push_back(d);
    else if (exp_ovf < 65535) exp_ovf++;
    repeat (hi) @(negedge DATA_CLK);
    FRAME_CLK = 1'b0;
    repeat (lo) @(negedge DATA_CLK);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(posedge AXI_CLK);
    check(tag, 64'(sb.size()), 64'd0);
    repeat (6) @(negedge AXI_CLK);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(AXI_DATA_VALID), 64'd0);
    check({tag, "_level"}, 64'(FIFO_LEVEL), 64'd0);
    check({tag, "_ovf"},   64'(OVERFLOW_COUNT), 64'd0);
    check({tag, "_data"},  64'(AXI_DATA), 64'd0);
  endtask

  initial begin
    #(64'd20_000_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] d;

    // FRAME_CLK held high through reset and beyond: no capture until it drops.
    repeat (3) @(negedge DATA_CLK);
    check_reset_state("rst0");
    RESET_N = 1'b1;
    repeat (10) @(negedge DATA_CLK);
    check("held_high_valid", 64'(AXI_DATA_VALID), 64'd0);
    check("held_high_level", 64'(FIFO_LEVEL), 64'd0);
    FRAME_CLK = 1'b0;
    repeat (2) @(negedge DATA_CLK);
    send_frame(rand_frame(), 2, 2);
    wait_drain("drain_first_edge");

    // Fixed pattern, READY high: each frame shows as a single VALID cycle.
    valid_cycles = 0;
    for (int i = 0; i < 3; i++) send_frame({14'h0004, 14'h0003, 14'h0002, 14'h0001}, 2, 2);
    wait_drain("drain_fixed");
    check("valid_pulses", 64'(valid_cycles), 64'd3);
    check("ovf_fixed", 64'(OVERFLOW_COUNT), 64'(exp_ovf));

    // READY low, 20 frames into a 16-frame FIFO.
    ready_mode = 0;
    for (int i = 0; i < 20; i++) begin
      d = rand_frame();
      d[DATA_W-1:0] = DATA_W'(i);
      send_frame(d, 2, 2);
    end
    repeat (10) @(negedge DATA_CLK);
    check("full_level", 64'(FIFO_LEVEL), 64'(sb.size()));
    check("full_ovf", 64'(OVERFLOW_COUNT), 64'(exp_ovf));
    check("full_valid", 64'(AXI_DATA_VALID), 64'd1);
    ready_mode = 1;
    wait_drain("drain_full");
    check("drained_valid", 64'(AXI_DATA_VALID), 64'd0);
    check("drained_level", 64'(FIFO_LEVEL), 64'd0);

    // Random back-pressure, 1000 frames with incrementing ch0 payload.
    ready_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      d = rand_frame();
      d[DATA_W-1:0] = DATA_W'(i);
      send_frame(d, 2, 2);
    end
    ready_mode = 1;
    wait_drain("drain_random");
    check("random_ovf", 64'(OVERFLOW_COUNT), 64'(exp_ovf));

    // Reset with 7 frames buffered: everything is discarded.
    ready_mode = 0;
    for (int i = 0; i < 7; i++) send_frame(rand_frame(), 2, 2);
    repeat (10) @(negedge DATA_CLK);
    check("pre_reset_level", 64'(FIFO_LEVEL), 64'(sb.size()));
    RESET_N = 1'b0;
    sb.delete();
    exp_ovf = 0;
    repeat (3) @(negedge DATA_CLK);
    check_reset_state("rst_mid");
    RESET_N = 1'b1;
    ready_mode = 1;
    repeat (4) @(negedge DATA_CLK);
    send_frame(rand_frame(), 2, 2);
    wait_drain("drain_post_reset");

    // Overflow saturation: fill, then drop more than 65535 frames.
    ready_mode = 0;
    axi_en = 1'b0;
    for (int i = 0; i < DEPTH + 65545; i++) send_frame(rand_frame(), 1, 1);
    axi_en = 1'b1;
    repeat (10) @(negedge DATA_CLK);
    check("sat_ovf", 64'(OVERFLOW_COUNT), 64'(exp_ovf));
    check("sat_level", 64'(FIFO_LEVEL), 64'(sb.size()));
    ready_mode = 1;
    wait_drain("drain_sat");
    check("sat_ovf_hold", 64'(OVERFLOW_COUNT), 64'(exp_ovf));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
